// File: rtl/updown_counter_core.sv
// rtl/updown_counter_core.sv - parametrised up/down counter with load, wrap/saturate, compare, tc and sticky ovf
// Optional prescaler divider compiled in with `define COUNTER_PRESCALE_EN.
module updown_counter_core #(
    parameter int WIDTH = 8
`ifdef COUNTER_PRESCALE_EN
    ,
    parameter int PRESCALE_W = 4
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] cmp_val,
    input  logic             clr_ovf,
`ifdef COUNTER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             match,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             match_q, match_d;
    logic             ovf_q, ovf_d;
    logic             boundary;
    logic             step_tick;

`ifdef COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0] div_q, div_d;

    // Equality compare means a divider above a lowered prescale runs to all-ones and wraps first.
    assign step_tick = (div_q == prescale);

    always_comb begin
        div_d = div_q;
        if (ena) begin
            if (load) begin
                div_d = '0;
            end else if (en) begin
                div_d = step_tick ? '0 : div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end
`else
    assign step_tick = 1'b1;
`endif

    always_comb begin
        count_d  = count_q;
        tc_d     = 1'b0;
        match_d  = match_q;
        ovf_d    = ovf_q;
        boundary = 1'b0;
        if (ena) begin
            if (load) begin
                count_d = load_val;
            end else if (en && step_tick) begin
                if (up) begin
                    if (count_q == MAX_VAL) begin
                        boundary = 1'b1;
                        if (!sat_mode) begin
                            count_d = '0;
                        end
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    if (count_q == '0) begin
                        boundary = 1'b1;
                        if (!sat_mode) begin
                            count_d = MAX_VAL;
                        end
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
            tc_d = boundary;
            // A boundary step in the same cycle as clr_ovf keeps the flag set.
            if (boundary) begin
                ovf_d = 1'b1;
            end else if (clr_ovf) begin
                ovf_d = 1'b0;
            end
            match_d = (count_d == cmp_val);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            match_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            match_q <= match_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign match = match_q;
    assign ovf   = ovf_q;

endmodule
